// File: rtl/cmos_nvram_arbiter.sv
// CMOS NVRAM arbiter: shares the battery-backed nibble RAM between the CPU and HPS load/save/clear jobs.
// Optional macro CMOS_DIRTY_TRACK_EN builds the CPU-write "dirty" tracker; otherwise dirty is tied low.
module cmos_nvram_arbiter #(
  parameter int unsigned       ADDR_W = 10,
  parameter int unsigned       DATA_W = 4,
  parameter logic [DATA_W-1:0] FILL   = '0
) (
  input  logic              clock_12,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_hold,
  input  logic              dn_active,
  input  logic              dn_wr,
  input  logic [ADDR_W-1:0] dn_addr,
  input  logic [7:0]        dn_data,
  input  logic              clear_req,
  input  logic              up_req,
  output logic [7:0]        up_data,
  output logic [ADDR_W-1:0] up_addr,
  output logic              up_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              dirty
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_SAVE_RD,
    S_SAVE_OUT
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_up_pend;
  logic              r_clr_armed;
  logic              r_cpu_acc;
  logic [DATA_W-1:0] r_cpu_dout;
  logic [7:0]        r_up_data;
  logic [ADDR_W-1:0] r_up_addr;
  logic              r_up_valid;

  logic w_cnt_last;
  logic w_go_clear;
  logic w_start;
  logic w_in_save;
  logic w_abort;
  logic w_beat;
  logic w_unused_dn;

  assign w_cnt_last  = &r_cnt;
  assign w_go_clear  = clear_req & r_clr_armed;
  assign w_start     = (r_state == S_IDLE) & (dn_active | w_go_clear | r_up_pend);
  assign w_in_save   = (r_state == S_SAVE_RD) | (r_state == S_SAVE_OUT);
  assign w_abort     = w_in_save & dn_active;
  assign w_beat      = (r_state == S_SAVE_OUT) & ~dn_active;
  assign w_unused_dn = ^dn_data[7:DATA_W];

  assign cpu_hold = (r_state != S_IDLE) | w_start;
  assign busy     = cpu_hold;
  assign up_data  = r_up_data;
  assign up_addr  = r_up_addr;
  assign up_valid = r_up_valid;

  // Pass-through of the registered RAM output on the cycle after a CPU access, held otherwise.
  assign cpu_dout = r_cpu_acc ? ram_dout : r_cpu_dout;

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    ram_addr = cpu_addr;
    ram_din  = cpu_din;
    ram_we   = cpu_we;
    unique case (r_state)
      S_IDLE: begin
        if (dn_active)       w_next = S_LOAD;
        else if (w_go_clear) w_next = S_CLEAR;
        else if (r_up_pend)  w_next = S_SAVE_RD;
      end
      S_LOAD: begin
        ram_addr = dn_addr;
        ram_din  = dn_data[DATA_W-1:0];
        ram_we   = dn_wr;
        if (!dn_active) w_next = S_IDLE;
      end
      S_CLEAR: begin
        ram_addr = r_cnt;
        ram_din  = FILL;
        ram_we   = 1'b1;
        if (w_cnt_last) w_next = S_IDLE;
      end
      S_SAVE_RD: begin
        ram_addr = r_cnt;
        ram_we   = 1'b0;
        w_next   = dn_active ? S_LOAD : S_SAVE_OUT;
      end
      S_SAVE_OUT: begin
        ram_addr = r_cnt;
        ram_we   = 1'b0;
        if (dn_active)       w_next = S_LOAD;
        else if (w_cnt_last) w_next = S_IDLE;
        else                 w_next = S_SAVE_RD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        S_CLEAR:    r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
        S_SAVE_RD:  if (dn_active) r_cnt <= '0;
        S_SAVE_OUT: r_cnt <= (dn_active || w_cnt_last) ? '0 : r_cnt + 1'b1;
        default:    r_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      r_up_pend   <= 1'b0;
      r_clr_armed <= 1'b1;
      r_cpu_acc   <= 1'b0;
      r_cpu_dout  <= '0;
      r_up_valid  <= 1'b0;
      r_up_data   <= '0;
      r_up_addr   <= '0;
    end else begin
      // A save abort discards the request; a fresh pulse otherwise wins over consumption.
      if (w_abort)                                 r_up_pend <= 1'b0;
      else if (up_req)                             r_up_pend <= 1'b1;
      else if (w_start && w_next == S_SAVE_RD)     r_up_pend <= 1'b0;

      if (w_start && w_next == S_CLEAR) r_clr_armed <= 1'b0;
      else if (!clear_req)              r_clr_armed <= 1'b1;

      r_cpu_acc  <= (r_state == S_IDLE) & ~w_start;
      r_cpu_dout <= cpu_dout;

      r_up_valid <= w_beat;
      if (w_beat) begin
        r_up_data <= 8'(ram_dout);
        r_up_addr <= r_cnt;
      end
    end
  end

`ifdef CMOS_DIRTY_TRACK_EN
  logic r_dirty;
  logic w_dirty_clr;

  assign w_dirty_clr = ((r_state == S_LOAD) & ~dn_active)
                     | ((r_state == S_CLEAR) & w_cnt_last)
                     | (w_beat & w_cnt_last);

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset)                              r_dirty <= 1'b0;
    else if (w_dirty_clr)                   r_dirty <= 1'b0;
    else if (r_state == S_IDLE && cpu_we)   r_dirty <= 1'b1;
  end

  assign dirty = r_dirty;
`else
  assign dirty = 1'b0;
`endif

endmodule

// File: tb/tb_cmos_nvram_arbiter.sv
// Self-checking bench for cmos_nvram_arbiter: CPU vector table, load/save/clear jobs, abort and reset corners.
module tb_cmos_nvram_arbiter;

`ifdef CMOS_DIRTY_TRACK_EN
  localparam logic DTRK = 1'b1;
`else
  localparam logic DTRK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] cpu_addr;
  logic [3:0] cpu_din;
  logic       cpu_we;
  logic [3:0] cpu_dout;
  logic       cpu_hold;
  logic       dn_active;
  logic       dn_wr;
  logic [9:0] dn_addr;
  logic [7:0] dn_data;
  logic       clear_req;
  logic       up_req;
  logic [7:0] up_data;
  logic [9:0] up_addr;
  logic       up_valid;
  logic [9:0] ram_addr;
  logic [3:0] ram_din;
  logic       ram_we;
  logic [3:0] ram_dout;
  logic       busy;
  logic       dirty;

  cmos_nvram_arbiter #(.ADDR_W(10), .DATA_W(4), .FILL(4'h0)) dut (
    .clock_12 (clk),
    .reset    (rst),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_we   (cpu_we),
    .cpu_dout (cpu_dout),
    .cpu_hold (cpu_hold),
    .dn_active(dn_active),
    .dn_wr    (dn_wr),
    .dn_addr  (dn_addr),
    .dn_data  (dn_data),
    .clear_req(clear_req),
    .up_req   (up_req),
    .up_data  (up_data),
    .up_addr  (up_addr),
    .up_valid (up_valid),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout),
    .busy     (busy),
    .dirty    (dirty)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM, read-before-write, 1-cycle read latency.
  logic [3:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  int beats  = 0;
  int last_v = -1;

  always @(posedge clk) cyc++;

  typedef struct {
    int         due;
    logic [3:0] exp;
  } rd_t;

  typedef struct {
    logic [9:0] a;
    logic [7:0] d;
  } up_t;

  rd_t rd_q[$];
  up_t up_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    else n_pass++;
  endtask

  // Scoreboard consumer: CPU read data and save beats are compared as the DUT produces them.
  always @(negedge clk) begin
    rd_t r;
    up_t u;
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      r = rd_q.pop_front();
      chk("cpu_rd", 32'(cpu_dout), 32'(r.exp));
    end
    if (up_valid === 1'b1) begin
      beats++;
      if (up_q.size() == 0) begin
        chk("up_unexpected", 32'(up_valid), 32'd0);
      end else begin
        u = up_q.pop_front();
        chk("up_beat", {14'd0, up_addr, up_data}, {14'd0, u.a, u.d});
        if (last_v >= 0) chk("up_gap", 32'(cyc - last_v), 32'd2);
        last_v = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_read(input logic [9:0] a, input logic [3:0] e);
    tick();
    cpu_addr = a;
    cpu_we   = 1'b0;
    rd_q.push_back('{cyc + 1, e});
  endtask

  task automatic cpu_write(input logic [9:0] a, input logic [3:0] d);
    tick();
    cpu_addr = a;
    cpu_din  = d;
    cpu_we   = 1'b1;
    tick();
    cpu_we   = 1'b0;
  endtask

  task automatic drain_reads(input string nm);
    tick();
    tick();
    @(negedge clk);
    chk(nm, 32'(rd_q.size()), 32'd0);
  endtask

  task automatic wait_up_empty(input int budget, input string nm);
    int n;
    n = 0;
    while (up_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(up_q.size()), 32'd0);
  endtask

  task automatic pulse_up_req();
    beats  = 0;
    last_v = -1;
    tick();
    up_req = 1'b1;
    tick();
    up_req = 1'b0;
  endtask

  typedef struct {
    logic       we;
    logic [9:0] addr;
    logic [3:0] din;
    logic [3:0] exp_rd;
    logic       exp_hold;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int  n;
    int  k;
    logic done;

    tbl = '{
      '{1'b1, 10'h155, 4'hA, 4'h0, 1'b0},
      '{1'b0, 10'h155, 4'h0, 4'hA, 1'b0},
      '{1'b1, 10'h000, 4'h3, 4'h0, 1'b0},
      '{1'b1, 10'h3FF, 4'hC, 4'h0, 1'b0},
      '{1'b0, 10'h000, 4'h0, 4'h3, 1'b0},
      '{1'b0, 10'h3FF, 4'h0, 4'hC, 1'b0},
      '{1'b1, 10'h155, 4'h7, 4'h0, 1'b0},
      '{1'b0, 10'h155, 4'h0, 4'h7, 1'b0},
      '{1'b0, 10'h3FF, 4'h0, 4'hC, 1'b0}
    };

    rst = 1'b1; cpu_addr = '0; cpu_din = '0; cpu_we = 1'b0;
    dn_active = 1'b0; dn_wr = 1'b0; dn_addr = '0; dn_data = '0;
    clear_req = 1'b0; up_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_dout", 32'(cpu_dout), 32'd0);
    chk("rst_up_valid", 32'(up_valid), 32'd0);
    chk("rst_up_data",  32'(up_data),  32'd0);
    chk("rst_up_addr",  32'(up_addr),  32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst_ram_we",   32'(ram_we),   32'd0);
    chk("rst_dirty",    32'(dirty),    32'd0);
    tick();
    rst = 1'b0;

    // CPU access table
    for (int i = 0; i < 9; i++) begin
      tick();
      cpu_addr = tbl[i].addr;
      cpu_din  = tbl[i].din;
      cpu_we   = tbl[i].we;
      if (!tbl[i].we) rd_q.push_back('{cyc + 1, tbl[i].exp_rd});
      @(negedge clk);
      chk($sformatf("tbl%0d_hold", i), 32'(cpu_hold), 32'(tbl[i].exp_hold));
    end
    tick();
    cpu_we = 1'b0;
    drain_reads("tbl_drain");
    chk("dirty_after_cpu_wr", 32'(dirty), 32'(DTRK));

    // Full image load: byte i carries i[3:0] in its low nibble
    n = 0;
    tick();
    dn_active = 1'b1;
    @(negedge clk);
    if (cpu_hold) n++;
    for (int i = 0; i < 1024; i++) begin
      tick();
      dn_wr   = 1'b1;
      dn_addr = 10'(i);
      dn_data = {4'hC, 4'(i)};
      @(negedge clk);
      if (cpu_hold) n++;
    end
    tick();
    dn_wr = 1'b0;
    dn_active = 1'b0;
    @(negedge clk);
    if (cpu_hold) n++;
    tick();
    @(negedge clk);
    chk("load_hold_release", 32'(cpu_hold), 32'd0);
    chk("load_hold_cycles", 32'(n), 32'd1026);
    chk("dirty_after_load", 32'(dirty), 32'd0);

    for (int i = 0; i < 1024; i++) cpu_read(10'(i), 4'(i));
    drain_reads("load_readback_drain");

    // Full save
    cpu_write(10'd5, 4'd5);
    @(negedge clk);
    chk("dirty_before_save", 32'(dirty), 32'(DTRK));
    for (int i = 0; i < 1024; i++) up_q.push_back('{10'(i), 8'(i & 15)});
    pulse_up_req();
    wait_up_empty(3000, "save_complete");
    tick();
    @(negedge clk);
    chk("save_busy_release", 32'(busy), 32'd0);
    chk("save_beats", 32'(beats), 32'd1024);
    chk("dirty_after_save", 32'(dirty), 32'd0);
    cpu_write(10'd5, 4'd5);
    @(negedge clk);
    chk("dirty_rewrite", 32'(dirty), 32'(DTRK));

    // Save aborted by a load at beat 300
    for (int i = 0; i < 1024; i++) up_q.push_back('{10'(i), 8'(i & 15)});
    pulse_up_req();
    n = 0;
    done = 1'b0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
      if (up_valid === 1'b1 && up_addr == 10'd300) done = 1'b1;
    end
    chk("abort_reach_beat300", 32'(done), 32'd1);
    #1;
    dn_active = 1'b1;
    up_q.delete();
    tick();
    tick();
    dn_wr   = 1'b1;
    dn_addr = 10'd7;
    dn_data = 8'h3E;
    tick();
    dn_wr = 1'b0;
    @(negedge clk);
    chk("abort_hold", 32'(cpu_hold), 32'd1);
    chk("dirty_during_abort", 32'(dirty), 32'(DTRK));
    repeat (20) tick();
    dn_active = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("abort_busy_release", 32'(busy), 32'd0);
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy) n++;
    end
    chk("abort_no_resume", 32'(n), 32'd0);
    chk("abort_beats", 32'(beats), 32'd301);
    cpu_read(10'd7, 4'hE);
    drain_reads("abort_load_drain");

    // Clear; busy includes the IDLE decision cycle
    cpu_write(10'd9, 4'hF);
    @(negedge clk);
    chk("dirty_before_clear", 32'(dirty), 32'(DTRK));
    tick();
    clear_req = 1'b1;
    n = 0;
    k = 0;
    done = 1'b0;
    while (!done && k < 2000) begin
      @(negedge clk);
      k++;
      if (busy) n++;
      else done = 1'b1;
    end
    chk("clear_busy_cycles", 32'(n), 32'd1025);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) n++;
    end
    chk("clear_no_restart", 32'(n), 32'd0);
    chk("dirty_after_clear", 32'(dirty), 32'd0);
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 1024; i++) cpu_read(10'(i), 4'h0);
    drain_reads("clear_readback_drain");

    // up_req latched during a clear, then reset in the middle of the resulting save
    tick();
    clear_req = 1'b1;
    repeat (100) tick();
    for (int i = 0; i < 1024; i++) up_q.push_back('{10'(i), 8'h00});
    pulse_up_req();
    k = 0;
    while (beats < 40 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk("latched_save_started", 32'(beats >= 40), 32'd1);
    #1;
    up_q.delete();
    clear_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_reset_busy", 32'(busy), 32'd0);
    chk("mid_reset_up_valid", 32'(up_valid), 32'd0);
    chk("mid_reset_dirty", 32'(dirty), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy) n++;
    end
    chk("post_reset_idle", 32'(n), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_tot);
    $fatal(1);
  end

endmodule
